usb_pid_decoder: RTL and testbench

//   Serial USB handshake/token PID decoder, successor to the single-pattern NAK detector.

---
 rtl/usb_pid_pkg.sv | 31 +++
 rtl/usb_sync_hunter.sv | 30 +++
 rtl/usb_pid_decoder.sv | 113 +++++++++++
 tb/tb_usb_pid_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usb_pid_pkg.sv
// Shared PID constants, FSM state encoding and PID check helper.
package usb_pid_pkg;

    localparam int unsigned PID_W = 8;
    localparam int unsigned CNT_W = 3;

    localparam logic [PID_W-1:0] PID_OUT   = 8'hE1;
    localparam logic [PID_W-1:0] PID_IN    = 8'h69;
    localparam logic [PID_W-1:0] PID_SOF   = 8'hA5;
    localparam logic [PID_W-1:0] PID_SETUP = 8'h2D;
    localparam logic [PID_W-1:0] PID_DATA0 = 8'hC3;
    localparam logic [PID_W-1:0] PID_DATA1 = 8'h4B;
    localparam logic [PID_W-1:0] PID_ACK   = 8'hD2;
    localparam logic [PID_W-1:0] PID_NAK   = 8'h5A;
    localparam logic [PID_W-1:0] PID_STALL = 8'h1E;
    localparam logic [PID_W-1:0] PID_NYET  = 8'h96;

    localparam logic ST_HUNT_ENC    = 1'b0;
    localparam logic ST_CAPTURE_ENC = 1'b1;

    typedef enum logic {
        ST_HUNT    = ST_HUNT_ENC,
        ST_CAPTURE = ST_CAPTURE_ENC
    } state_t;

    // Upper nibble must be the bitwise complement of the lower nibble.
    function automatic logic pid_check_ok(input logic [PID_W-1:0] p);
        return p[7:4] == ~p[3:0];
    endfunction

endpackage

// File: rtl/usb_sync_hunter.sv
// SYNC window shift register with compare against the configured end-of-SYNC pattern.
module usb_sync_hunter #(
    parameter int unsigned         SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(8'h01)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bit,
    input  logic i_shift,
    input  logic i_clear,
    output logic o_sync_hit_c
);

    logic [SYNC_LEN-1:0] r_window;
    logic [SYNC_LEN-1:0] w_next;

    assign w_next       = {r_window[SYNC_LEN-2:0], i_bit};
    // Hit is judged on the window including the bit being shifted in now.
    assign o_sync_hit_c = i_shift && (w_next == SYNC_PATTERN);

    // Window update: cleared on reset/abort/capture end, shifted on valid hunt bits.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_window <= '0;
        end else if (i_shift) begin
            r_window <= w_next;
        end
    end

endmodule

// File: rtl/usb_pid_decoder.sv
// Serial USB PID decoder: SYNC hunt, LSB-first PID capture, check and type decode.
module usb_pid_decoder
    import usb_pid_pkg::*;
#(
    parameter int unsigned         SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(8'h01),
    parameter logic [PID_W-1:0]    MATCH_PID    = 8'h5A,
    parameter int unsigned         ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 abort,
    output logic [PID_W-1:0]     pid,
    output logic                 pid_valid,
    output logic                 pid_error,
    output logic                 pid_match,
    output logic                 is_ack,
    output logic                 is_nak,
    output logic                 is_stall,
    output logic                 is_nyet,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t           r_state;
    logic [PID_W-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;

    logic             w_shift;
    logic             w_last;
    logic             w_clear;
    logic             w_sync_hit;
    logic [PID_W-1:0] w_byte;
    logic             w_ok;

    assign w_shift = bit_valid && !abort && (r_state == ST_HUNT);
    assign w_last  = bit_valid && !abort && (r_state == ST_CAPTURE) && (r_cnt == CNT_W'(7));
    assign w_clear = abort || w_last;
    assign w_byte  = {bit_in, r_shreg[PID_W-1:1]};
    assign w_ok    = pid_check_ok(w_byte);

    usb_sync_hunter #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_hunter (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_bit        (bit_in),
        .i_shift      (w_shift),
        .i_clear      (w_clear),
        .o_sync_hit_c (w_sync_hit)
    );

    // Capture FSM with registered PID, pulses, type flags and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HUNT;
            r_shreg   <= '0;
            r_cnt     <= '0;
            pid       <= '0;
            pid_valid <= 1'b0;
            pid_error <= 1'b0;
            pid_match <= 1'b0;
            is_ack    <= 1'b0;
            is_nak    <= 1'b0;
            is_stall  <= 1'b0;
            is_nyet   <= 1'b0;
            err_count <= '0;
        end else begin
            pid_valid <= 1'b0;
            pid_error <= 1'b0;
            pid_match <= 1'b0;
            if (abort) begin
                r_state <= ST_HUNT;
                r_cnt   <= '0;
            end else if (bit_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_sync_hit) begin
                            r_state <= ST_CAPTURE;
                            r_cnt   <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        r_shreg <= w_byte;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            pid       <= w_byte;
                            pid_valid <= w_ok;
                            pid_error <= !w_ok;
                            pid_match <= w_ok && (w_byte == MATCH_PID);
                            is_ack    <= w_ok && (w_byte == PID_ACK);
                            is_nak    <= w_ok && (w_byte == PID_NAK);
                            is_stall  <= w_ok && (w_byte == PID_STALL);
                            is_nyet   <= w_ok && (w_byte == PID_NYET);
                            if (!w_ok && (err_count != '1)) begin
                                err_count <= err_count + ERR_CNT_W'(1);
                            end
                            r_state <= ST_HUNT;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_pid_decoder.sv
// Directed scoreboard bench for usb_pid_decoder.
module tb_usb_pid_decoder;

    typedef struct packed {
        logic [7:0] pid;
        logic       v;
        logic       e;
        logic       m;
        logic [3:0] flags;   // {ack, nak, stall, nyet}
        logic [7:0] err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       abort;
    logic [7:0] pid;
    logic       pid_valid;
    logic       pid_error;
    logic       pid_match;
    logic       is_ack;
    logic       is_nak;
    logic       is_stall;
    logic       is_nyet;
    logic [7:0] err_count;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_err = 0;

    usb_pid_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .abort     (abort),
        .pid       (pid),
        .pid_valid (pid_valid),
        .pid_error (pid_error),
        .pid_match (pid_match),
        .is_ack    (is_ack),
        .is_nak    (is_nak),
        .is_stall  (is_stall),
        .is_nyet   (is_nyet),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample #1 after the edge, score pulses.
    task automatic step(input logic b, input logic v, input logic ab);
        exp_t e;
        bit_in    = b;
        bit_valid = v;
        abort     = ab;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pid",       32'(pid), 32'(e.pid));
            chk("pid_valid", 32'(pid_valid), 32'(e.v));
            chk("pid_error", 32'(pid_error), 32'(e.e));
            chk("pid_match", 32'(pid_match), 32'(e.m));
            chk("flags",     32'({is_ack, is_nak, is_stall, is_nyet}), 32'(e.flags));
            chk("err_count", 32'(err_count), 32'(e.err));
        end else begin
            chk("idle_pulses", 32'({pid_valid, pid_error, pid_match}), 32'd0);
        end
    endtask

    task automatic send_sync(input bit toggle);
        logic [7:0] s;
        s = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0);
            if (toggle) step(1'b1, 1'b0, 1'b0);
        end
    endtask

    // Sends nbits PID bits LSB first; queues the bench-computed result before the 8th.
    task automatic send_pid(input logic [7:0] p, input int nbits, input bit toggle);
        exp_t e;
        logic ok;
        for (int i = 0; i < nbits; i++) begin
            if (i == 7) begin
                ok = (p[7:4] == ~p[3:0]);
                if (!ok && exp_err < 255) exp_err++;
                e.pid   = p;
                e.v     = ok;
                e.e     = !ok;
                e.m     = ok && (p == 8'h5A);
                e.flags = {ok && p == 8'hD2, ok && p == 8'h5A, ok && p == 8'h1E, ok && p == 8'h96};
                e.err   = 8'(exp_err);
                q.push_back(e);
            end
            step(p[i], 1'b1, 1'b0);
            if (toggle) step(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pid",   32'(pid), 32'h00);
        chk("rst_pulse", 32'({pid_valid, pid_error, pid_match}), 32'd0);
        chk("rst_flags", 32'({is_ack, is_nak, is_stall, is_nyet}), 32'd0);
        chk("rst_err",   32'(err_count), 32'd0);

        // 1: contiguous NAK
        send_sync(1'b0);
        send_pid(8'h5A, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // 2: ACK with bit_valid toggling
        send_sync(1'b1);
        send_pid(8'hD2, 8, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("ack_hold", 32'({is_ack, pid}), 32'h1D2);

        // 3: bad check nibble, then saturation
        for (int n = 0; n < 300; n++) begin
            send_sync(1'b0);
            send_pid(8'h5B, 8, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("err_sat", 32'(err_count), 32'd255);
        chk("err_pid_loaded", 32'(pid), 32'h5B);

        // 4: abort after 4 PID bits, then STALL
        send_sync(1'b0);
        send_pid(8'h5A, 4, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        chk("abort_pid_kept", 32'(pid), 32'h5B);
        chk("abort_flags", 32'({is_ack, is_nak, is_stall, is_nyet}), 32'd0);
        send_sync(1'b0);
        send_pid(8'h1E, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("stall_hold", 32'({is_stall, pid}), 32'h11E);

        // 5: reset after 5th PID bit
        send_sync(1'b0);
        send_pid(8'h5A, 5, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_err = 0;
        chk("mid_rst_pid",   32'(pid), 32'h00);
        chk("mid_rst_flags", 32'({is_ack, is_nak, is_stall, is_nyet}), 32'd0);
        chk("mid_rst_err",   32'(err_count), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        send_sync(1'b0);
        send_pid(8'h5A, 8, 1'b0);

        // 6: back-to-back NAK then NYET, no gap
        send_sync(1'b0);
        send_pid(8'h5A, 8, 1'b0);
        send_sync(1'b0);
        send_pid(8'h96, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("nyet_hold", 32'({is_nyet, is_nak, pid}), 32'h296);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
